mod_stream_sched: RTL and testbench

- Frame scheduler in front of the modulator's S00 AXI-Stream input.
- Shares the single modulator input between two AXI-Stream sources using round-robin arbitration at frame granularity.
- Closes each frame on a programmed beat count or on the source's tlast, whichever comes first.
- Inserts a programmable idle gap between frames.

---
 rtl/mod_sched_pkg.sv | 36 +++
 rtl/mod_rr_arb2.sv | 38 +++
 rtl/mod_stream_sched.sv | 198 +++++++++++++++++++
 tb/tb_mod_stream_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_sched_pkg.sv
// mod_sched_pkg
// Shared definitions for the modulator input frame scheduler:
//   - scheduler state encoding
//   - default widths for data, length/gap fields and the frame counter
//   - source identifier type and the two-way round-robin pick helper
package mod_sched_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 16;
  localparam int CNT_WIDTH_DEF  = 32;
  localparam int NUM_SRC        = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // One bit identifies source 0 or source 1.
  typedef logic src_id_t;

  // With both sources requesting, the one not served last wins;
  // otherwise the lone requester wins.
  function automatic src_id_t rr_pick(input src_id_t last_grant, input logic [1:0] req);
    src_id_t pick;
    if (req[0] && req[1]) begin
      pick = ~last_grant;
    end else if (req[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mod_rr_arb2.sv
// mod_rr_arb2
// Two-requester round-robin arbiter with a last-grant register.
// Ports:
//   clk        - clock
//   srst       - synchronous active-high reset; last grant returns to 0,
//                so requester 1 holds first priority afterwards
//   enable     - permits a grant this cycle
//   req        - request vector, one bit per requester
//   grant_stb  - single-cycle strobe: a grant is issued this cycle
//   last_grant - requester granted most recently (updates on the strobe edge)
module mod_rr_arb2
  import mod_sched_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       enable,
  input  logic [1:0] req,
  output logic       grant_stb,
  output src_id_t    last_grant
);

  src_id_t last_grant_reg;
  src_id_t grant_sel;

  assign grant_stb = enable & (|req);
  assign grant_sel = rr_pick(last_grant_reg, req);

  always_ff @(posedge clk) begin
    if (srst) begin
      last_grant_reg <= 1'b0;
    end else if (grant_stb) begin
      last_grant_reg <= grant_sel;
    end
  end

  assign last_grant = last_grant_reg;

endmodule

// File: rtl/mod_stream_sched.sv
// mod_stream_sched
// Frame scheduler sharing the modulator's single AXI-Stream input between
// two AXI-Stream sources. Sources are granted round-robin per frame; a
// frame closes on the programmed beat count or on the source tlast,
// whichever comes first, and is followed by a programmable idle gap.
// Ports:
//   m00_axis_aclk / m00_axis_areset - clock, synchronous active-high reset
//   cfg_enable     - permits new grants (only looked at while idle)
//   cfg_frame_len  - beats per frame (0 behaves as 1)
//   cfg_gap        - idle cycles inserted after each frame
//   s00_axis_*     - source 0 stream (tdata/tstrb/tlast/tvalid in, tready out)
//   s01_axis_*     - source 1 stream
//   m00_axis_*     - stream towards the modulator
//   grant_id       - source currently or most recently granted
//   busy           - transferring a frame or inserting the gap
//   frame_cnt      - completed frames, wraps
module mod_stream_sched
  import mod_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                    m00_axis_aclk,
  input  logic                    m00_axis_areset,
  input  logic                    cfg_enable,
  input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
  input  logic [LEN_WIDTH-1:0]    cfg_gap,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tlast,
  input  logic                    s00_axis_tvalid,
  output logic                    s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tlast,
  input  logic                    s01_axis_tvalid,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  output logic                    m00_axis_tvalid,
  input  logic                    m00_axis_tready,
  output logic                    grant_id,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    frame_cnt
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Sources gathered into arrays so the grant id can index them directly.
  logic [DATA_WIDTH-1:0] src_tdata [NUM_SRC];
  logic [STRB_WIDTH-1:0] src_tstrb [NUM_SRC];
  logic [NUM_SRC-1:0]    src_tvalid;
  logic [NUM_SRC-1:0]    src_tlast;
  logic [NUM_SRC-1:0]    src_tready;

  assign src_tdata[0]  = s00_axis_tdata;
  assign src_tdata[1]  = s01_axis_tdata;
  assign src_tstrb[0]  = s00_axis_tstrb;
  assign src_tstrb[1]  = s01_axis_tstrb;
  assign src_tvalid    = {s01_axis_tvalid, s00_axis_tvalid};
  assign src_tlast     = {s01_axis_tlast, s00_axis_tlast};
  assign s00_axis_tready = src_tready[0];
  assign s01_axis_tready = src_tready[1];

  sched_state_t         state_reg, state_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [LEN_WIDTH-1:0] gap_reg, gap_next;
  logic [LEN_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;
  logic [LEN_WIDTH-1:0] gap_cnt_reg, gap_cnt_next;
  logic [CNT_WIDTH-1:0] frame_cnt_reg, frame_cnt_next;

  logic    arb_enable;
  logic    grant_stb;
  src_id_t last_grant;

  // Grants are only considered while idle; reset overrides everything.
  assign arb_enable = (state_reg == IDLE) & cfg_enable & ~m00_axis_areset;

  mod_rr_arb2 u_arb (
    .clk        (m00_axis_aclk),
    .srst       (m00_axis_areset),
    .enable     (arb_enable),
    .req        (src_tvalid),
    .grant_stb  (grant_stb),
    .last_grant (last_grant)
  );

  // The arbiter's last-grant register already holds the owner once XFER
  // is entered, so it doubles as the mux select.
  logic xfer_act;
  logic sel_tvalid;
  logic sel_tlast;
  logic frame_last;
  logic beat_done;

  assign xfer_act   = (state_reg == XFER) & ~m00_axis_areset;
  assign sel_tvalid = src_tvalid[last_grant];
  assign sel_tlast  = src_tlast[last_grant];
  // len_reg is never 0, so len_reg-1 cannot underflow.
  assign frame_last = (beat_cnt_reg == (len_reg - LEN_WIDTH'(1))) | sel_tlast;
  assign beat_done  = xfer_act & sel_tvalid & m00_axis_tready;

  // State register
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_reg     <= IDLE;
      len_reg       <= LEN_WIDTH'(1);
      gap_reg       <= '0;
      beat_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      gap_reg       <= gap_next;
      beat_cnt_reg  <= beat_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    gap_next       = gap_reg;
    beat_cnt_next  = beat_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_stb) begin
          // Frame parameters are frozen here so later config writes
          // only affect the next frame.
          len_next      = (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
          gap_next      = cfg_gap;
          beat_cnt_next = '0;
          state_next    = XFER;
        end
      end
      XFER: begin
        if (beat_done) begin
          if (frame_last) begin
            frame_cnt_next = frame_cnt_reg + CNT_WIDTH'(1);
            beat_cnt_next  = '0;
            if (gap_reg != '0) begin
              gap_cnt_next = gap_reg;
              state_next   = GAP;
            end else begin
              state_next = IDLE;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);
          end
        end
      end
      GAP: begin
        // Entered with gap_cnt = gap, leaving on 1 gives exactly gap cycles.
        gap_cnt_next = gap_cnt_reg - LEN_WIDTH'(1);
        if (gap_cnt_reg == LEN_WIDTH'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    m00_axis_tdata  = '0;
    m00_axis_tstrb  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    busy            = 1'b0;
    if (xfer_act) begin
      m00_axis_tdata  = src_tdata[last_grant];
      m00_axis_tstrb  = src_tstrb[last_grant];
      m00_axis_tvalid = sel_tvalid;
      m00_axis_tlast  = frame_last;
    end
    if (!m00_axis_areset && (state_reg != IDLE)) begin
      busy = 1'b1;
    end
  end

  // Only the owner sees the modulator's ready; the other source is held off.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
    assign src_tready[gi] = xfer_act & (last_grant == src_id_t'(gi)) & m00_axis_tready;
  end

  assign grant_id  = last_grant;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_mod_stream_sched.sv
// tb_mod_stream_sched
// Directed bench for mod_stream_sched. Sources are fed from word queues;
// a frame-level behavioural model predicts every output each cycle and a
// beat log is checked against hand-computed expectations per scenario.
module tb_mod_stream_sched;

  logic        clk;
  logic        rst;
  logic        cfg_enable;
  logic [15:0] cfg_frame_len;
  logic [15:0] cfg_gap;
  logic [31:0] s00_axis_tdata;
  logic [3:0]  s00_axis_tstrb;
  logic        s00_axis_tlast;
  logic        s00_axis_tvalid;
  logic        s00_axis_tready;
  logic [31:0] s01_axis_tdata;
  logic [3:0]  s01_axis_tstrb;
  logic        s01_axis_tlast;
  logic        s01_axis_tvalid;
  logic        s01_axis_tready;
  logic [31:0] m00_axis_tdata;
  logic [3:0]  m00_axis_tstrb;
  logic        m00_axis_tlast;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready;
  logic        grant_id;
  logic        busy;
  logic [31:0] frame_cnt;

  mod_stream_sched dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .cfg_enable      (cfg_enable),
    .cfg_frame_len   (cfg_frame_len),
    .cfg_gap         (cfg_gap),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tstrb  (s01_axis_tstrb),
    .s01_axis_tlast  (s01_axis_tlast),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tready (s01_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .grant_id        (grant_id),
    .busy            (busy),
    .frame_cnt       (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  word_t q0[$];
  word_t q1[$];
  beat_t log_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_cnt = 0;

  // Model: who owns the port, how many beats remain before a forced close,
  // how many quiet cycles remain, and who was served last.
  int          m_mode  = 0;   // 0 idle, 1 frame open, 2 quiet gap
  int          m_owner = 0;
  int          m_last  = 0;
  int          m_left  = 0;
  int          m_gap   = 0;
  int          m_quiet = 0;
  logic [31:0] m_frames = 0;
  bit          m_known = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic load(input int src, input logic [31:0] base, input int n, input int last_idx);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.data = base + 32'(i);
      w.last = (i == last_idx);
      if (src == 0) q0.push_back(w);
      else q1.push_back(w);
    end
  endtask

  task automatic drive_srcs();
    s00_axis_tvalid = 1'b0; s00_axis_tdata = '0; s00_axis_tstrb = '0; s00_axis_tlast = 1'b0;
    s01_axis_tvalid = 1'b0; s01_axis_tdata = '0; s01_axis_tstrb = '0; s01_axis_tlast = 1'b0;
    if (q0.size() > 0) begin
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = q0[0].data;
      s00_axis_tstrb  = q0[0].data[3:0];
      s00_axis_tlast  = q0[0].last;
    end
    if (q1.size() > 0) begin
      s01_axis_tvalid = 1'b1;
      s01_axis_tdata  = q1[0].data;
      s01_axis_tstrb  = q1[0].data[3:0];
      s01_axis_tlast  = q1[0].last;
    end
  endtask

  // Per-cycle comparison of every output against the model, then advance
  // the model by one clock using the inputs that will be sampled.
  task automatic model_cycle();
    bit          xfer, sv, sl, e_valid, e_last;
    logic [31:0] sd;
    logic [3:0]  ss;
    xfer = (m_mode == 1);
    sv = (m_owner == 0) ? s00_axis_tvalid : s01_axis_tvalid;
    sl = (m_owner == 0) ? s00_axis_tlast  : s01_axis_tlast;
    sd = (m_owner == 0) ? s00_axis_tdata  : s01_axis_tdata;
    ss = (m_owner == 0) ? s00_axis_tstrb  : s01_axis_tstrb;
    e_valid = xfer && sv;
    e_last  = xfer && ((m_left == 1) || sl);
    if (rst) begin
      chk("rst_m_tvalid", 64'(m00_axis_tvalid), 64'(0));
      chk("rst_m_tlast",  64'(m00_axis_tlast),  64'(0));
      chk("rst_s00_tready", 64'(s00_axis_tready), 64'(0));
      chk("rst_s01_tready", 64'(s01_axis_tready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
    end else begin
      chk("m_tvalid", 64'(m00_axis_tvalid), 64'(e_valid));
      chk("m_tlast",  64'(m00_axis_tlast),  64'(e_last));
      chk("s00_tready", 64'(s00_axis_tready), 64'(xfer && m_owner == 0 && m00_axis_tready));
      chk("s01_tready", 64'(s01_axis_tready), 64'(xfer && m_owner == 1 && m00_axis_tready));
      chk("busy", 64'(busy), 64'(m_mode != 0));
      if (e_valid) begin
        chk("m_tdata", 64'(m00_axis_tdata), 64'(sd));
        chk("m_tstrb", 64'(m00_axis_tstrb), 64'(ss));
      end
    end
    if (m_known) begin
      chk("grant_id", 64'(grant_id), 64'(m_last));
      chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
    end
    if (rst) begin
      m_mode = 0; m_last = 0; m_frames = 0; m_known = 1;
    end else begin
      case (m_mode)
        0: if (cfg_enable && (s00_axis_tvalid || s01_axis_tvalid)) begin
             if (s00_axis_tvalid && s01_axis_tvalid) m_owner = 1 - m_last;
             else m_owner = s00_axis_tvalid ? 0 : 1;
             m_last = m_owner;
             m_left = (cfg_frame_len == 16'd0) ? 1 : int'(cfg_frame_len);
             m_gap  = int'(cfg_gap);
             m_mode = 1;
           end
        1: if (e_valid && m00_axis_tready) begin
             if (e_last) begin
               m_frames = m_frames + 32'd1;
               if (m_gap > 0) begin
                 m_quiet = m_gap;
                 m_mode  = 2;
               end else begin
                 m_mode = 0;
               end
             end else begin
               m_left = m_left - 1;
             end
           end
        default: begin
          m_quiet = m_quiet - 1;
          if (m_quiet == 0) m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic step();
    bit    hs0, hs1;
    beat_t b;
    @(negedge clk);
    model_cycle();
    hs0 = s00_axis_tvalid && s00_axis_tready;
    hs1 = s01_axis_tvalid && s01_axis_tready;
    if (m00_axis_tvalid && !m00_axis_tready) stall_cnt++;
    if (m00_axis_tvalid && m00_axis_tready) begin
      b.data = m00_axis_tdata;
      b.last = m00_axis_tlast;
      b.cyc  = cyc;
      log_q.push_back(b);
      $display("beat cyc=%0d grant=%0d data=%h last=%0b frames=%0d",
               cyc, grant_id, m00_axis_tdata, m00_axis_tlast, frame_cnt);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs0) q0.delete(0);
    if (hs1) q1.delete(0);
    drive_srcs();
  endtask

  // Runs until both sources are drained and the scheduler is idle.
  task automatic run_until_quiet(input int limit, input bit toggle_ready);
    int  n;
    bit  done;
    logic [3:0] pat;
    pat  = 4'b1001;
    n    = 0;
    done = 0;
    while (!done && n < limit) begin
      if (toggle_ready) m00_axis_tready = pat[n % 4];
      step();
      n++;
      done = (q0.size() == 0) && (q1.size() == 0) && !busy;
    end
    m00_axis_tready = 1'b1;
    chk("run_timeout", 64'(done), 64'(1));
  endtask

  task automatic run_until_beats(input int nbeats, input int limit);
    int n;
    n = 0;
    while (log_q.size() < nbeats && n < limit) begin
      step();
      n++;
    end
    chk("beat_timeout", 64'(log_q.size() >= nbeats), 64'(1));
  endtask

  initial begin
    rst = 1'b1;
    cfg_enable = 1'b0;
    cfg_frame_len = 16'd4;
    cfg_gap = 16'd0;
    m00_axis_tready = 1'b1;
    drive_srcs();

    // Reset
    repeat (3) step();
    rst = 1'b0;
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("post_rst_grant_id", 64'(grant_id), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));

    // Single source, len 4, no gap
    log_q.delete();
    cfg_enable = 1'b1; cfg_frame_len = 16'd4; cfg_gap = 16'd0;
    load(0, 32'hA000_0100, 8, -1);
    drive_srcs();
    run_until_quiet(100, 0);
    chk("t1_beats", 64'(log_q.size()), 64'(8));
    chk("t1_last3", 64'(log_q[3].last), 64'(1));
    chk("t1_last2", 64'(log_q[2].last), 64'(0));
    chk("t1_last7", 64'(log_q[7].last), 64'(1));
    chk("t1_data4", 64'(log_q[4].data), 64'(32'hA000_0104));
    chk("t1_regrant_gap", 64'(log_q[4].cyc - log_q[3].cyc), 64'(2));
    chk("t1_frames", 64'(frame_cnt), 64'(2));

    // Both sources, len 3, gap 2
    log_q.delete();
    cfg_frame_len = 16'd3; cfg_gap = 16'd2;
    load(0, 32'hA000_0200, 3, -1);
    load(1, 32'hA000_0300, 6, -1);
    drive_srcs();
    run_until_quiet(100, 0);
    chk("t2_beats", 64'(log_q.size()), 64'(9));
    chk("t2_first_s01", 64'(log_q[0].data), 64'(32'hA000_0300));
    chk("t2_second_s00", 64'(log_q[3].data), 64'(32'hA000_0200));
    chk("t2_third_s01", 64'(log_q[6].data), 64'(32'hA000_0303));
    chk("t2_last2", 64'(log_q[2].last), 64'(1));
    chk("t2_last8", 64'(log_q[8].last), 64'(1));
    chk("t2_frame_spacing", 64'(log_q[3].cyc - log_q[2].cyc), 64'(4));
    chk("t2_frames", 64'(frame_cnt), 64'(5));

    // Early tlast from source 0 with len 8
    log_q.delete();
    cfg_frame_len = 16'd8; cfg_gap = 16'd0;
    load(0, 32'hA000_0400, 2, 1);
    load(1, 32'hA000_0500, 3, 2);
    drive_srcs();
    run_until_quiet(100, 0);
    chk("t3_beats", 64'(log_q.size()), 64'(5));
    chk("t3_first_s00", 64'(log_q[0].data), 64'(32'hA000_0400));
    chk("t3_early_last", 64'(log_q[1].last), 64'(1));
    chk("t3_beat0_last", 64'(log_q[0].last), 64'(0));
    chk("t3_other_src", 64'(log_q[2].data), 64'(32'hA000_0500));
    chk("t3_frames", 64'(frame_cnt), 64'(7));

    // Backpressure 1,0,0,1 during a len 5 frame
    log_q.delete();
    stall_cnt = 0;
    cfg_frame_len = 16'd5;
    load(0, 32'hA000_0600, 5, -1);
    drive_srcs();
    run_until_quiet(100, 1);
    chk("t4_beats", 64'(log_q.size()), 64'(5));
    chk("t4_data0", 64'(log_q[0].data), 64'(32'hA000_0600));
    chk("t4_data4", 64'(log_q[4].data), 64'(32'hA000_0604));
    chk("t4_last4", 64'(log_q[4].last), 64'(1));
    chk("t4_last3", 64'(log_q[3].last), 64'(0));
    chk("t4_stalls_seen", 64'(stall_cnt > 0), 64'(1));
    chk("t4_frames", 64'(frame_cnt), 64'(8));

    // Enable dropped mid-frame, length changed
    log_q.delete();
    cfg_frame_len = 16'd6;
    load(1, 32'hA000_0700, 8, -1);
    drive_srcs();
    run_until_beats(2, 50);
    cfg_enable = 1'b0;
    cfg_frame_len = 16'd2;
    repeat (20) step();
    chk("t5_beats", 64'(log_q.size()), 64'(6));
    chk("t5_last5", 64'(log_q[5].last), 64'(1));
    chk("t5_last1", 64'(log_q[1].last), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_m_tvalid", 64'(m00_axis_tvalid), 64'(0));
    chk("t5_s01_tready", 64'(s01_axis_tready), 64'(0));
    chk("t5_frames", 64'(frame_cnt), 64'(9));
    cfg_enable = 1'b1;
    run_until_quiet(100, 0);
    chk("t5_beats_after", 64'(log_q.size()), 64'(8));
    chk("t5_newlen_last", 64'(log_q[7].last), 64'(1));
    chk("t5_frames_after", 64'(frame_cnt), 64'(10));

    // Zero length behaves as one beat, gap 1
    log_q.delete();
    cfg_frame_len = 16'd0; cfg_gap = 16'd1;
    load(0, 32'hA000_0B00, 2, -1);
    drive_srcs();
    run_until_quiet(100, 0);
    chk("t7_beats", 64'(log_q.size()), 64'(2));
    chk("t7_last0", 64'(log_q[0].last), 64'(1));
    chk("t7_last1", 64'(log_q[1].last), 64'(1));
    chk("t7_spacing", 64'(log_q[1].cyc - log_q[0].cyc), 64'(3));
    chk("t7_frames", 64'(frame_cnt), 64'(12));

    // Reset during beat 3 of 5
    log_q.delete();
    cfg_frame_len = 16'd5; cfg_gap = 16'd0;
    load(0, 32'hA000_0800, 5, 4);
    load(1, 32'hA000_0900, 5, 4);
    drive_srcs();
    run_until_beats(2, 50);
    rst = 1'b1;
    step();
    chk("t6_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("t6_grant_id", 64'(grant_id), 64'(0));
    chk("t6_m_tvalid", 64'(m00_axis_tvalid), 64'(0));
    chk("t6_s00_tready", 64'(s00_axis_tready), 64'(0));
    chk("t6_s01_tready", 64'(s01_axis_tready), 64'(0));
    rst = 1'b0;
    run_until_beats(3, 50);
    chk("t6_regrant_s01", 64'(log_q[2].data), 64'(32'hA000_0902));
    run_until_quiet(100, 0);
    chk("t6_beats", 64'(log_q.size()), 64'(10));
    chk("t6_last4", 64'(log_q[4].last), 64'(1));
    chk("t6_data9", 64'(log_q[9].data), 64'(32'hA000_0804));
    chk("t6_frames", 64'(frame_cnt), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
